// File: rtl/bpf_pktmem_reader_pkg.sv
// Shared definitions for the packet-memory read responder.
//   xfer_sz_e   : load size encodings carried on transfer_sz
//   own_state_e : buffer ownership states (writer -> CPU -> writer)
//   sz_bytes()  : byte count of a load size (0 for the illegal code)
package bpf_pktmem_reader_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } xfer_sz_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } own_state_e;

   function automatic logic [2:0] sz_bytes(input logic [1:0] sz);
      logic [2:0] n;
      case (sz)
         SZ_B:    n = 3'd1;
         SZ_H:    n = 3'd2;
         SZ_W:    n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/bpf_pktmem_reader_align.sv
// bpf_load_align: combinational byte-lane extractor.
//   win    in  64  {word W, word W+1}, byte k at bits [63-8k -: 8]
//   off    in  2   starting byte offset inside word W
//   sz     in  2   load size (byte/half/word; illegal code yields 0)
//   result out 32  selected bytes, big-endian, right-justified, zero-extended
module bpf_load_align
   import bpf_pktmem_reader_pkg::*;
(
   input  logic [63:0] win,
   input  logic [1:0]  off,
   input  logic [1:0]  sz,
   output logic [31:0] result
);

   logic [63:0] shifted;

   always_comb begin
      // Bring byte 'off' to the top of the window, then take the top n bytes.
      shifted = win << {off, 3'b000};
      result  = '0;
      case (sz)
         SZ_B:    result = {24'h0, shifted[63:56]};
         SZ_H:    result = {16'h0, shifted[63:48]};
         SZ_W:    result = shifted[63:32];
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/bpf_pktmem_reader.sv
// bpf_pktmem_reader: read responder and ownership controller for one packet
// buffer shared between a packet writer and the BPF CPU.
//   clk, rst                 clock, async active-high reset
//   buf_full, pkt_len        writer hand-off (sampled in IDLE)
//   buf_release,
//   verdict_accept           buffer return pulse and its verdict
//   mem_ready                packet owned by the CPU (RUN)
//   accept, reject           CPU verdict pulses
//   packet_mem_rd_en,
//   rd_addr, transfer_sz     CPU load request
//   rd_data, rd_valid,
//   rd_oob                   load response
//   mem_rd_en, mem_rd_addr0/1,
//   mem_rd_data0/1           dual-word packet memory read port
module bpf_pktmem_reader
   import bpf_pktmem_reader_pkg::*;
#(
   parameter int unsigned BYTE_ADDR_WIDTH = 12,
   parameter bit          PESSIMISTIC     = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       buf_full,
   input  logic [BYTE_ADDR_WIDTH:0]   pkt_len,
   output logic                       buf_release,
   output logic                       verdict_accept,
   output logic                       mem_ready,
   input  logic                       accept,
   input  logic                       reject,
   input  logic                       packet_mem_rd_en,
   input  logic [BYTE_ADDR_WIDTH-1:0] rd_addr,
   input  logic [1:0]                 transfer_sz,
   output logic [31:0]                rd_data,
   output logic                       rd_valid,
   output logic                       rd_oob,
   output logic                       mem_rd_en,
   output logic [BYTE_ADDR_WIDTH-3:0] mem_rd_addr0,
   output logic [BYTE_ADDR_WIDTH-3:0] mem_rd_addr1,
   input  logic [31:0]                mem_rd_data0,
   input  logic [31:0]                mem_rd_data1
);

   localparam int unsigned AW = BYTE_ADDR_WIDTH;
   localparam int unsigned WW = BYTE_ADDR_WIDTH - 2;

   own_state_e      state_q, state_d;
   logic [AW:0]     len_q, len_d;
   logic            verdict_q, verdict_d;

   logic            vld_q, vld_d;
   logic [1:0]      off_q, off_d;
   logic [1:0]      sz_q, sz_d;
   logic            oob_q, oob_d;

   logic            issue;
   logic [2:0]      n_bytes;
   logic [AW:0]     end_addr;
   logic [31:0]     aligned;
   logic [31:0]     lane_data;
   logic            lane_oob;

   // Ownership FSM
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      verdict_d = verdict_q;
      case (state_q)
         IDLE: begin
            if (buf_full) begin
               len_d   = pkt_len;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept || reject) begin
               verdict_d = accept & ~reject;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Load issue: address/size/bounds are captured alongside the memory read
   always_comb begin
      issue    = packet_mem_rd_en && (state_q == RUN);
      n_bytes  = sz_bytes(transfer_sz);
      end_addr = {1'b0, rd_addr} + {{(AW-2){1'b0}}, n_bytes};
      vld_d    = issue;
      off_d    = rd_addr[1:0];
      sz_d     = transfer_sz;
      oob_d    = (transfer_sz == SZ_X) || (end_addr > len_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         verdict_q <= 1'b0;
         vld_q     <= 1'b0;
         off_q     <= '0;
         sz_q      <= '0;
         oob_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         verdict_q <= verdict_d;
         vld_q     <= vld_d;
         off_q     <= off_d;
         sz_q      <= sz_d;
         oob_q     <= oob_d;
      end
   end

   assign mem_ready      = (state_q == RUN);
   assign buf_release    = (state_q == DONE);
   assign verdict_accept = verdict_q;
   assign mem_rd_en      = issue;
   assign mem_rd_addr0   = rd_addr[AW-1:2];
   assign mem_rd_addr1   = rd_addr[AW-1:2] + {{(WW-1){1'b0}}, 1'b1};

   bpf_load_align u_align (
      .win    ({mem_rd_data0, mem_rd_data1}),
      .off    (off_q),
      .sz     (sz_q),
      .result (aligned)
   );

   // Outputs are forced to zero unless a response is actually presented.
   assign lane_data = (vld_q && !oob_q) ? aligned : '0;
   assign lane_oob  = vld_q & oob_q;

   if (PESSIMISTIC) begin : g_out_reg
      logic        out_vld_q, out_vld_d;
      logic [31:0] out_data_q, out_data_d;
      logic        out_oob_q, out_oob_d;

      always_comb begin
         out_vld_d  = vld_q;
         out_data_d = lane_data;
         out_oob_d  = lane_oob;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_oob_q  <= 1'b0;
         end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_oob_q  <= out_oob_d;
         end
      end

      assign rd_valid = out_vld_q;
      assign rd_data  = out_data_q;
      assign rd_oob   = out_oob_q;
   end else begin : g_out_comb
      assign rd_valid = vld_q;
      assign rd_data  = lane_data;
      assign rd_oob   = lane_oob;
   end

endmodule

// File: tb/tb_bpf_pktmem_reader.sv
// Bench for bpf_pktmem_reader: one instance with PESSIMISTIC=0 and one with
// PESSIMISTIC=1 share the same stimulus; each has its own memory model and
// response scoreboard.
module tb_bpf_pktmem_reader;

   localparam int AW = 12;
   localparam int NW = 1 << (AW - 2);

   logic            clk = 1'b0;
   logic            rst;
   logic            buf_full;
   logic [AW:0]     pkt_len;
   logic            accept, reject;
   logic            packet_mem_rd_en;
   logic [AW-1:0]   rd_addr;
   logic [1:0]      transfer_sz;

   logic [1:0]      buf_release, verdict_accept, mem_ready;
   logic [1:0]      rd_valid, rd_oob, mem_rd_en;
   logic [31:0]     rd_data [2];
   logic [AW-3:0]   mem_rd_addr0 [2];
   logic [AW-3:0]   mem_rd_addr1 [2];
   logic [31:0]     md0 [2];
   logic [31:0]     md1 [2];

   logic [31:0]     mem [NW];
   logic [AW:0]     mdl_len;
   int              cyc = 0;
   int              n_checks = 0;
   int              n_bad = 0;

   typedef struct {
      logic [31:0] data;
      logic        oob;
      int          issued;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mem_rd_en[i]) begin
            md0[i] <= mem[mem_rd_addr0[i]];
            md1[i] <= mem[mem_rd_addr1[i]];
         end
      end
   end

   bpf_pktmem_reader #(.BYTE_ADDR_WIDTH(AW), .PESSIMISTIC(1'b0)) dut0 (
      .clk(clk), .rst(rst), .buf_full(buf_full), .pkt_len(pkt_len),
      .buf_release(buf_release[0]), .verdict_accept(verdict_accept[0]),
      .mem_ready(mem_ready[0]), .accept(accept), .reject(reject),
      .packet_mem_rd_en(packet_mem_rd_en), .rd_addr(rd_addr),
      .transfer_sz(transfer_sz), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
      .rd_oob(rd_oob[0]), .mem_rd_en(mem_rd_en[0]),
      .mem_rd_addr0(mem_rd_addr0[0]), .mem_rd_addr1(mem_rd_addr1[0]),
      .mem_rd_data0(md0[0]), .mem_rd_data1(md1[0])
   );

   bpf_pktmem_reader #(.BYTE_ADDR_WIDTH(AW), .PESSIMISTIC(1'b1)) dut1 (
      .clk(clk), .rst(rst), .buf_full(buf_full), .pkt_len(pkt_len),
      .buf_release(buf_release[1]), .verdict_accept(verdict_accept[1]),
      .mem_ready(mem_ready[1]), .accept(accept), .reject(reject),
      .packet_mem_rd_en(packet_mem_rd_en), .rd_addr(rd_addr),
      .transfer_sz(transfer_sz), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
      .rd_oob(rd_oob[1]), .mem_rd_en(mem_rd_en[1]),
      .mem_rd_addr0(mem_rd_addr0[1]), .mem_rd_addr1(mem_rd_addr1[1]),
      .mem_rd_data0(md0[1]), .mem_rd_data1(md1[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Byte-by-byte reference for a load against the current packet length.
   function automatic exp_t model(input logic [AW-1:0] a, input logic [1:0] sz,
                                  input logic [AW:0] len);
      exp_t r;
      int n, b;
      logic [31:0] w;
      r.data = '0;
      r.oob = 1'b0;
      r.issued = cyc;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (sz == 2'd3 || int'(a) + n > int'(len)) begin
         r.oob = 1'b1;
      end else begin
         for (int k = 0; k < n; k++) begin
            b = (int'(a) + k) % (1 << AW);
            w = mem[b / 4];
            r.data = (r.data << 8) | ((w >> (8 * (3 - b % 4))) & 32'hFF);
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin : mon0
      exp_t e;
      if (!rst && rd_valid[0]) begin
         chk("p0_pending", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("p0_data", rd_data[0], e.data);
            chk("p0_oob", 32'(rd_oob[0]), 32'(e.oob));
            chk("p0_latency", cyc, e.issued + 1);
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (!rst && rd_valid[1]) begin
         chk("p1_pending", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("p1_data", rd_data[1], e.data);
            chk("p1_oob", 32'(rd_oob[1]), 32'(e.oob));
            chk("p1_latency", cyc, e.issued + 2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [1:0] sz);
      exp_t e;
      e = model(a, sz, mdl_len);
      q0.push_back(e);
      q1.push_back(e);
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [1:0] sz, input bit live);
      packet_mem_rd_en = 1'b1;
      rd_addr = a;
      transfer_sz = sz;
      if (live) push(a, sz);
      step();
      packet_mem_rd_en = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk(tag, 32'({mem_ready, buf_release, verdict_accept, rd_valid, rd_oob, mem_rd_en}), 32'd0);
      chk({tag, "_data"}, rd_data[0] | rd_data[1], 32'd0);
   endtask

   task automatic drain();
      repeat (3) step();
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      buf_full = 1'b0;
      pkt_len = '0;
      accept = 1'b0;
      reject = 1'b0;
      packet_mem_rd_en = 1'b0;
      rd_addr = '0;
      transfer_sz = '0;
      mdl_len = '0;
      for (int w = 0; w < NW; w++) mem[w] = $urandom;
      mem[0] = 32'h11223344;
      mem[1] = 32'h55667788;

      repeat (2) step();
      chk_reset_outs("reset");
      rst = 1'b0;
      step();

      // Load in IDLE is dropped
      packet_mem_rd_en = 1'b1;
      rd_addr = 12'd1;
      transfer_sz = 2'd0;
      #1 chk("idle_rden", 32'(mem_rd_en), 32'd0);
      step();
      packet_mem_rd_en = 1'b0;
      drain();

      // Hand-off with pkt_len = 8
      buf_full = 1'b1;
      pkt_len = 13'd8;
      #1 chk("ready_early", 32'(mem_ready), 32'd0);
      step();
      buf_full = 1'b0;
      mdl_len = 13'd8;
      chk("ready_rise", 32'(mem_ready), 32'h3);

      load(12'd1, 2'd0, 1'b1);
      load(12'd3, 2'd1, 1'b1);
      load(12'd2, 2'd2, 1'b1);
      for (int i = 0; i < 24; i++)
         load(12'($urandom_range(0, 9)), 2'($urandom_range(0, 3)), 1'b1);
      drain();

      // buf_full while in RUN must not re-latch the length
      buf_full = 1'b1;
      pkt_len = 13'd6;
      step();
      buf_full = 1'b0;
      load(12'd4, 2'd2, 1'b1);

      // Simultaneous accept+reject, with a load issued in the same cycle
      accept = 1'b1;
      reject = 1'b1;
      packet_mem_rd_en = 1'b1;
      rd_addr = 12'd0;
      transfer_sz = 2'd2;
      push(12'd0, 2'd2);
      step();
      accept = 1'b0;
      reject = 1'b0;
      rd_addr = 12'd1;
      #1 chk("done_rden", 32'(mem_rd_en), 32'd0);
      chk("rel_pulse", 32'(buf_release), 32'h3);
      chk("verdict_rej", 32'(verdict_accept), 32'd0);
      chk("ready_drop", 32'(mem_ready), 32'd0);
      step();
      packet_mem_rd_en = 1'b0;
      chk("rel_once", 32'(buf_release), 32'd0);
      drain();

      // Second packet, pkt_len = 6
      buf_full = 1'b1;
      pkt_len = 13'd6;
      step();
      buf_full = 1'b0;
      mdl_len = 13'd6;
      load(12'd4, 2'd1, 1'b1);
      load(12'd4, 2'd2, 1'b1);
      load(12'd0, 2'd3, 1'b1);
      load(12'd2, 2'd2, 1'b1);
      load(12'd5, 2'd0, 1'b1);
      load(12'd5, 2'd1, 1'b1);
      accept = 1'b1;
      step();
      accept = 1'b0;
      chk("rel_acc", 32'(buf_release), 32'h3);
      chk("verdict_acc", 32'(verdict_accept), 32'h3);
      step();
      chk("verdict_hold", 32'(verdict_accept), 32'h3);
      drain();

      // Zero-length packet: every load is out of bounds
      buf_full = 1'b1;
      pkt_len = 13'd0;
      step();
      buf_full = 1'b0;
      mdl_len = 13'd0;
      load(12'd0, 2'd0, 1'b1);
      drain();

      // Reset with a load in flight
      load(12'd1, 2'd0, 1'b0);
      rst = 1'b1;
      #1 chk_reset_outs("midrst");
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_norel", 32'(buf_release), 32'd0);
      end
      rst = 1'b0;
      step();
      chk("post_rst", 32'({buf_release, mem_ready, rd_valid}), 32'd0);
      drain();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/bpf_pktmem_reader.md
# bpf_pktmem_reader

Read-side responder and buffer-ownership controller for one packet buffer, sitting between the pipelined BPF CPU controller/datapath and the packet memory. It gives the CPU a packet once the writer has filled it, serves the CPU's byte, halfword and word loads at arbitrary byte addresses, and flags out-of-bounds loads. It releases the buffer back to the writer when the CPU issues accept or reject.

## Interface
- `BYTE_ADDR_WIDTH`, 12: byte address width. The buffer holds 2^BYTE_ADDR_WIDTH bytes as 32-bit big-endian words.
- `PESSIMISTIC`, 0: when 1, adds an output register stage, so read latency is +1.

- `clk`  in  1  clock. Everything is synchronous to its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `buf_full`  in  1  writer has finished the packet. Sampled only in IDLE.
- `pkt_len`  in  BYTE_ADDR_WIDTH+1  packet byte length. Latched on the accepted `buf_full`.
- `buf_release`  out  1  one-cycle pulse: buffer returned to the writer.
- `verdict_accept`  out  1  verdict that goes with `buf_release`. Held until the next verdict.
- `mem_ready`  out  1  to CPU: packet available. High only in RUN.
- `accept`, `reject`  in  1 each  CPU verdict pulses.
- `packet_mem_rd_en`  in  1  CPU load request.
- `rd_addr`  in  BYTE_ADDR_WIDTH  byte address of the load.
- `transfer_sz`  in  2  load size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `rd_data`  out  32  load result, right-justified and zero-extended.
- `rd_valid`  out  1  `rd_data` / `rd_oob` are valid this cycle.
- `rd_oob`  out  1  the load was out of bounds or illegal.
- `mem_rd_en`  out  1  memory read enable, same cycle as the request.
- `mem_rd_addr0`, `mem_rd_addr1`  out  BYTE_ADDR_WIDTH-2 each  word addresses W and W+1.
- `mem_rd_data0`, `mem_rd_data1`  in  32 each  memory read data, valid one cycle after `mem_rd_en`.

## Operation
- **Ownership FSM: IDLE → RUN → DONE → IDLE.**
  - IDLE: on `buf_full`, latch `pkt_len` and go to RUN.
  - RUN: `mem_ready`=1. On `accept` or `reject`, go to DONE and register `verdict_accept` = `accept & ~reject`. If both are high in the same cycle, the verdict is reject.
  - DONE: `buf_release`=1 for exactly one cycle, then IDLE.
  - `buf_full` is ignored outside IDLE. `accept`/`reject` are ignored outside RUN.
- **Loads** are accepted only in RUN. `packet_mem_rd_en` in other states is dropped: no memory read, no `rd_valid`.
- **Addressing.** W = `rd_addr[BYTE_ADDR_WIDTH-1:2]`, o = `rd_addr[1:0]`.
  - Both W and W+1 are always issued. W+1 wraps modulo the word count.
  - Form the 64-bit value {data0, data1}; byte k is bits [63-8k -: 8].
  - Result = bytes o .. o+n-1, with n = 1, 2 or 4, placed big-endian in the low bits and zero-extended.
- **Bounds.** Compute `rd_addr` + n in BYTE_ADDR_WIDTH+1 bits with no overflow.
  - If the sum exceeds the latched `pkt_len`, or `transfer_sz` = 11: `rd_oob`=1 and `rd_data`=0.
  - `pkt_len` = 0 makes every load out of bounds.
- **Pipelining.** Request address, size and the OOB flag are registered alongside the memory read. One load per cycle is sustained.
- **Reset mid-operation.** Go to IDLE and clear all in-flight valids. No `buf_release` pulse is produced.
- **Mid-read verdict.** A load already issued before the DONE transition still completes and returns `rd_valid`.

## Timing
- Load issued in cycle T:
  - PESSIMISTIC=0: `rd_valid`/`rd_data` in T+1, combinational from the memory data.
  - PESSIMISTIC=1: in T+2, from a register.
- `mem_ready` rises the cycle after `buf_full` is sampled in IDLE.
- `buf_release` is high in the cycle after `accept`/`reject` is seen.
- A new `buf_full` is accepted starting the cycle after `buf_release`.
- Reset values: `mem_ready`=0, `buf_release`=0, `verdict_accept`=0, `rd_valid`=0, `rd_oob`=0, `rd_data`=0, `mem_rd_en`=0; latched `pkt_len` = 0.

## Structure
- Shared package holds:
  - `transfer_sz` encodings: SZ_B, SZ_H, SZ_W.
  - FSM state encodings: IDLE, RUN, DONE.
- One sub-module, `bpf_load_align`: a combinational byte-lane extractor taking ({data0, data1}, o, size) and returning the zero-extended result.

## Test plan
Preload memory with word0 = 0x11223344, word1 = 0x55667788, and `pkt_len` = 8 unless stated otherwise.
1. Byte load at addr 1 → `rd_data` = 0x00000022, `rd_oob` = 0, one cycle after the request (PESSIMISTIC=0).
2. Half load at addr 3 → 0x00004455. Word load at addr 2 → 0x33445566. Issue them back-to-back → two consecutive `rd_valid` cycles.
3. With `pkt_len` = 6: half load at addr 4 → 0x00005566, `rd_oob` = 0. Word load at addr 4 → `rd_oob` = 1, `rd_data` = 0. `transfer_sz` = 11 → `rd_oob` = 1.
4. Handshake: `buf_full` → `mem_ready` = 1 next cycle. `accept` and `reject` in the same cycle → one `buf_release` pulse, `verdict_accept` = 0, `mem_ready` = 0.
5. Load requested in IDLE → no `mem_rd_en`, no `rd_valid`. `buf_full` asserted in RUN → `pkt_len` is not re-latched.
6. Assert `rst` mid-RUN with a load in flight → outputs at reset values immediately, no `rd_valid`, no `buf_release`. Repeat cases 1–2 with PESSIMISTIC=1 → latency is 2 cycles.
